// File: rtl/spi_rx_pipe_buffer.sv
// spi_rx_pipe_buffer
// Captures 32-bit words from an SPI slave in the clk domain, carries them into
// the ti_clk domain over a toggle request/acknowledge handshake, and buffers
// them in a FIFO that the host drains one 16-bit half per pipe_read (low half
// first). Optional build macro: SPI_RX_SEQCHK_EN enables the incrementing
// sequence checker that drives seq_err_cnt; otherwise seq_err_cnt is zero.
module spi_rx_pipe_buffer #(
    parameter int unsigned DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  ti_clk,
    input  logic                  reset_global,
    input  logic                  rx_valid,
    input  logic [31:0]           rx_data,
    input  logic                  pipe_read,
    output logic [15:0]           pipe_data,
    output logic                  pipe_ready,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow,
    output logic                  underflow,
    output logic [15:0]           drop_cnt,
    output logic [15:0]           seq_err_cnt
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    // ---------------- reset synchronisers ----------------
    logic [1:0] rst_clk_sr;
    logic [1:0] rst_ti_sr;
    logic       rst_clk;
    logic       rst_ti;

    // clk-domain reset: asserts immediately, releases after two clk edges
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) rst_clk_sr <= '1;
        else              rst_clk_sr <= {rst_clk_sr[0], 1'b0};
    end

    // ti_clk-domain reset: asserts immediately, releases after two ti_clk edges
    always_ff @(posedge ti_clk or posedge reset_global) begin
        if (reset_global) rst_ti_sr <= '1;
        else              rst_ti_sr <= {rst_ti_sr[0], 1'b0};
    end

    assign rst_clk = rst_clk_sr[1];
    assign rst_ti  = rst_ti_sr[1];

    // ---------------- clk domain: capture side ----------------
    logic        req_tgl;
    logic        ack_s1;
    logic        ack_s2;
    logic [31:0] hold_reg;
    logic        ack_tgl;

    // Latch a word when the handshake is idle, otherwise count the drop
    always_ff @(posedge clk or posedge rst_clk) begin
        if (rst_clk) begin
            req_tgl  <= 1'b0;
            ack_s1   <= 1'b0;
            ack_s2   <= 1'b0;
            hold_reg <= '0;
            drop_cnt <= '0;
        end else begin
            ack_s1 <= ack_tgl;
            ack_s2 <= ack_s1;
            if (rx_valid) begin
                if (req_tgl == ack_s2) begin
                    hold_reg <= rx_data;
                    req_tgl  <= ~req_tgl;
                end else if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end

    // ---------------- ti_clk domain: FIFO side ----------------
    logic                  req_s1;
    logic                  req_s2;
    logic [DEPTH_LOG2:0]   wr_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr;
    logic                  half_sel;
    logic                  empty;
    logic                  full;
    logic                  wr_req;
    logic                  pop;
    logic                  wr_en;
    logic [31:0]           mem [DEPTH];
    logic [31:0]           head;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                    (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    // A pending request is simply synced req differing from our ack toggle
    assign wr_req = (req_s2 != ack_tgl);
    assign pop    = pipe_read && !empty && half_sel;
    // A full FIFO still accepts when the head word is popped this cycle
    assign wr_en  = wr_req && (!full || pop);

    // Handshake acknowledge, pointer updates and sticky status flags
    always_ff @(posedge ti_clk or posedge rst_ti) begin
        if (rst_ti) begin
            req_s1    <= 1'b0;
            req_s2    <= 1'b0;
            ack_tgl   <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            half_sel  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            req_s1 <= req_tgl;
            req_s2 <= req_s1;
            if (wr_req) begin
                ack_tgl <= ~ack_tgl;
                if (!wr_en) overflow <= 1'b1;
            end
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pipe_read) begin
                if (empty) begin
                    underflow <= 1'b1;
                end else begin
                    half_sel <= ~half_sel;
                    if (half_sel) rd_ptr <= rd_ptr + PTR_ONE;
                end
            end
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge ti_clk) begin
        if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= hold_reg;
    end

    assign head       = mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign pipe_data  = empty ? 16'h0000 : (half_sel ? head[31:16] : head[15:0]);
    assign fifo_count = wr_ptr - rd_ptr;
    assign pipe_ready = !empty;

`ifdef SPI_RX_SEQCHK_EN
    logic [31:0] last_word;
    logic        have_last;
    logic [15:0] seq_cnt;

    // Compare each accepted word with its predecessor + 1
    always_ff @(posedge ti_clk or posedge rst_ti) begin
        if (rst_ti) begin
            last_word <= '0;
            have_last <= 1'b0;
            seq_cnt   <= '0;
        end else if (wr_en) begin
            last_word <= hold_reg;
            have_last <= 1'b1;
            if (have_last && (hold_reg != last_word + 32'd1) && (seq_cnt != '1))
                seq_cnt <= seq_cnt + 16'd1;
        end
    end

    assign seq_err_cnt = seq_cnt;
`else
    assign seq_err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_spi_rx_pipe_buffer.sv
// Self-checking bench for spi_rx_pipe_buffer (small FIFO, DEPTH_LOG2=2).
// Expected half-words are queued when words are sent and compared on reads.
module tb_spi_rx_pipe_buffer;

    localparam int unsigned DL    = 2;
    localparam int unsigned DEPTH = 1 << DL;

    logic          clk = 1'b0;
    logic          ti_clk = 1'b0;
    logic          reset_global;
    logic          rx_valid;
    logic [31:0]   rx_data;
    logic          pipe_read;
    logic [15:0]   pipe_data;
    logic          pipe_ready;
    logic [DL:0]   fifo_count;
    logic          overflow;
    logic          underflow;
    logic [15:0]   drop_cnt;
    logic [15:0]   seq_err_cnt;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;
    always #7 ti_clk = ~ti_clk;

    spi_rx_pipe_buffer #(.DEPTH_LOG2(DL)) dut (
        .clk          (clk),
        .ti_clk       (ti_clk),
        .reset_global (reset_global),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .pipe_read    (pipe_read),
        .pipe_data    (pipe_data),
        .pipe_ready   (pipe_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .underflow    (underflow),
        .drop_cnt     (drop_cnt),
        .seq_err_cnt  (seq_err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int unsigned model_count();
        return (exp_q.size() + 1) / 2;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, ".count"},     32'(fifo_count), 32'd0);
        check({tag, ".ready"},     32'(pipe_ready), 32'd0);
        check({tag, ".data"},      32'(pipe_data), 32'd0);
        check({tag, ".overflow"},  32'(overflow), 32'd0);
        check({tag, ".underflow"}, 32'(underflow), 32'd0);
        check({tag, ".drop"},      32'(drop_cnt), 32'd0);
        check({tag, ".seq"},       32'(seq_err_cnt), 32'd0);
    endtask

    task automatic do_reset();
        reset_global = 1'b1;
        #3;
        check_reset_outputs("reset");
        repeat (4) @(negedge clk);
        reset_global = 1'b0;
        exp_q.delete();
        repeat (6) @(negedge ti_clk);
    endtask

    // One rx_valid pulse; the scoreboard takes it if the model has room
    task automatic pulse(input logic [31:0] w);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = w;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    task automatic send_word(input logic [31:0] w);
        bit accept;
        accept = (model_count() < DEPTH);
        pulse(w);
        if (accept) begin
            exp_q.push_back(w[15:0]);
            exp_q.push_back(w[31:16]);
        end
        repeat (20) @(negedge clk);
        @(negedge ti_clk);
        check("send.count", 32'(fifo_count), 32'(model_count()));
    endtask

    task automatic read_half(input string tag);
        logic [15:0] exp;
        @(negedge ti_clk);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'h0000;
        check({tag, ".data"}, 32'(pipe_data), 32'(exp));
        pipe_read = 1'b1;
        @(negedge ti_clk);
        pipe_read = 1'b0;
        check({tag, ".count"}, 32'(fifo_count), 32'(model_count()));
    endtask

    initial begin
        reset_global = 1'b1;
        rx_valid     = 1'b0;
        rx_data      = '0;
        pipe_read    = 1'b0;
        do_reset();

        // Two words spaced far apart, read back as four halves
        send_word(32'h12345678);
        repeat (1000) @(negedge clk);
        send_word(32'h9ABCDEF0);
        check("basic.ready", 32'(pipe_ready), 32'd1);
        for (int i = 0; i < 4; i++) read_half("basic");
        check("basic.ready_after", 32'(pipe_ready), 32'd0);
        check("basic.underflow", 32'(underflow), 32'd0);

        // Read while empty
        read_half("empty");
        check("empty.underflow", 32'(underflow), 32'd1);
        check("empty.ready", 32'(pipe_ready), 32'd0);

        // Second pulse lands while the handshake is still busy
        do_reset();
        pulse(32'hCAFE0001);
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'hCAFE);
        @(negedge clk);
        pulse(32'hCAFE0002);
        repeat (20) @(negedge clk);
        check("busy.drop", 32'(drop_cnt), 32'd1);
        @(negedge ti_clk);
        check("busy.count", 32'(fifo_count), 32'd1);
        read_half("busy");
        read_half("busy");

        // Overflow: five words into a four-deep FIFO
        do_reset();
        for (int i = 1; i <= 5; i++) send_word(32'h11110000 * i + 32'(i));
        check("ovf.count", 32'(fifo_count), 32'd4);
        check("ovf.flag", 32'(overflow), 32'd1);
        check("ovf.ready", 32'(pipe_ready), 32'd1);
        for (int i = 0; i < 8; i++) read_half("ovf");
        check("ovf.ready_after", 32'(pipe_ready), 32'd0);

        // Sequence checker: one gap in 5,6,7,9,10
        do_reset();
        begin
            logic [31:0] seq_words [5];
            seq_words = '{32'd5, 32'd6, 32'd7, 32'd9, 32'd10};
            for (int i = 0; i < 5; i++) begin
                send_word(seq_words[i]);
                read_half("seq");
                read_half("seq");
            end
        end
`ifdef SPI_RX_SEQCHK_EN
        check("seq.count", 32'(seq_err_cnt), 32'd1);
`else
        check("seq.count", 32'(seq_err_cnt), 32'd0);
`endif

        // Reset after one half of a three-word FIFO
        do_reset();
        send_word(32'h01010101);
        send_word(32'h02020202);
        send_word(32'h03030303);
        read_half("mid");
        do_reset();
        check_reset_outputs("post");
        send_word(32'hAAAA5555);
        read_half("post");
        read_half("post");
        check("post.ready", 32'(pipe_ready), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net against a stalled run
    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_rx_pipe_buffer.md
SPI_RX_PIPE_BUFFER -- requirements
Module: spi_rx_pipe_buffer

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 6; FIFO depth = 2**DEPTH_LOG2 32-bit words.
REQ-002 SHALL have port clk  in  1  SPI-side clock (clk1); drives the rx_* inputs and drop_cnt.
REQ-003 SHALL have port ti_clk  in  1  host-interface clock; drives the pipe and status logic.
REQ-004 SHALL have port reset_global  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rx_valid  in  1  one-clk pulse from the SPI slave (rdy) marking a complete word.
REQ-006 SHALL have port rx_data  in  32  received word; valid while rx_valid=1.
REQ-007 SHALL have port pipe_read  in  1  ti_clk host pipe-out read strobe; one 16-bit half per cycle.
REQ-008 SHALL have port pipe_data  out  16  current half-word presented to the pipe.
REQ-009 SHALL have port pipe_ready  out  1  1 when FIFO count >= 1.
REQ-010 SHALL have port fifo_count  out  DEPTH_LOG2+1  words stored, in the ti_clk domain.
REQ-011 SHALL have port overflow  out  1  sticky; set when a word is lost because the FIFO is full.
REQ-012 SHALL have port underflow  out  1  sticky; set on pipe_read while the FIFO is empty.
REQ-013 SHALL have port drop_cnt  out  16  clk-domain count of rx_valid pulses dropped because the handshake was busy.
REQ-014 SHALL have port seq_err_cnt  out  16  sequence-check error count (see Configuration).

Function
REQ-015 Capture: on clk with rx_valid=1 and the handshake idle (req_tgl == synced ack_tgl), SHALL latch rx_data into hold_reg and toggle req_tgl.
REQ-016 Busy: rx_valid=1 while the handshake is busy SHALL leave hold_reg unchanged and increment drop_cnt, saturating at 16'hFFFF.
REQ-017 The crossing SHALL synchronise req_tgl into ti_clk through 2 flops; ack_tgl SHALL pass back into clk through 2 flops.
REQ-018 On a detected req edge, the ti_clk side SHALL write hold_reg into the FIFO and toggle ack_tgl in the same cycle; when the FIFO is full, the word is discarded, overflow is set, and ack is still toggled.
REQ-019 Write latency: rx_valid to fifo_count increment SHALL be at most 4 ti_clk cycles after the toggle is sampled.
REQ-020 Read order: each word SHALL be output as the low half [15:0] first, then the high half [31:16]; a half-select flag toggles on every pipe_read.
REQ-021 pipe_data SHALL combinationally present the half selected at the head of the FIFO; the FIFO pops on the pipe_read that consumes the high half.
REQ-022 pipe_read on an empty FIFO SHALL return 16'h0000, set underflow, and leave the half-select and pointers unchanged.
REQ-023 A simultaneous write and pop in the same cycle SHALL leave fifo_count unchanged; a write to a full FIFO in the same cycle as a pop SHALL be accepted.
REQ-024 Read and write pointers SHALL be DEPTH_LOG2+1 bits and wrap modulo 2**(DEPTH_LOG2+1); full = MSBs differ and the rest are equal.

Reset
REQ-025 reset_global SHALL asynchronously clear: pointers, fifo_count=0, half-select=low, pipe_ready=0, overflow=0, underflow=0, drop_cnt=0, seq_err_cnt=0, req/ack toggles and synchronisers=0, hold_reg=0.
REQ-026 Reset mid-word SHALL discard all stored and held data; the first word after release SHALL be output as the low half first.
REQ-027 Release of reset SHALL be synchronised per domain (2-flop) before logic leaves reset.

Configuration
REQ-028 With macro SPI_RX_SEQCHK_EN defined, every word written to the FIFO (except the first after reset) SHALL be compared with the previous written word + 1 (mod 2**32); each mismatch increments seq_err_cnt, saturating.
REQ-029 Without SPI_RX_SEQCHK_EN, the compare logic SHALL be absent and seq_err_cnt SHALL be tied to 16'h0000.

Verification
REQ-030 Inputs 32'h12345678 then 32'h9ABCDEF0, spaced 1000 clk apart; 4 pipe_reads -> pipe_data 5678, 1234, DEF0, 9ABC; fifo_count 2->0; pipe_ready falls after the 4th read.
REQ-031 With DEPTH_LOG2=2, 5 words pushed with no reads -> fifo_count=4, overflow=1; reads return words 1-4 only.
REQ-032 Two rx_valid pulses 2 clk apart -> first word stored, drop_cnt=1.
REQ-033 pipe_read with the FIFO empty -> pipe_data=0000, underflow=1, fifo_count stays 0.
REQ-034 With SPI_RX_SEQCHK_EN, words 5,6,7,9,10 -> seq_err_cnt=1; without the macro -> seq_err_cnt=0.
REQ-035 reset_global asserted after one half-word read of a 3-word FIFO -> all outputs at reset values; next word 32'hAAAA5555 reads out 5555 then AAAA.
